zc_period_meter: RTL

Parametrised zero-crossing period meter. It is the successor to the fixed-width zero-cross detector that follows the interpolating FIR. It consumes the filtered signed sample stream with a per-sample valid strobe. It detects rising zero crossings with programmable hysteresis and a hold-off, and reports the instantaneous period in samples, a block-averaged period, a lock indicator and a timeout/overflow indication.

---
 rtl/zc_period_meter_if.sv | 26 ++
 rtl/zc_period_meter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/zc_period_meter_if.sv
// Sample-stream and measurement bundle for zc_period_meter.
// The master drives the filtered sample stream; the slave (meter) returns results.
interface zc_period_meter_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] x;
  logic                     flag;
  logic        [CNT_W-1:0]  period;
  logic                     period_valid;
  logic        [CNT_W-1:0]  period_avg;
  logic                     avg_valid;
  logic                     locked;
  logic                     overflow;

  modport master (
    output in_valid, x,
    input  flag, period, period_valid, period_avg, avg_valid, locked, overflow
  );

  modport slave (
    input  in_valid, x,
    output flag, period, period_valid, period_avg, avg_valid, locked, overflow
  );
endinterface

// File: rtl/zc_period_meter.sv
// Zero-crossing period meter: rising-crossing detector with hysteresis and
// glitch hold-off, instantaneous period, block-averaged period, lock and
// sticky counter-timeout indication. Only valid samples advance the state.
module zc_period_meter #(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int HYST       = 0,
  parameter int MIN_PERIOD = 2,
  parameter int AVG_LOG2   = 2
) (
  input  logic            clk,
  input  logic            reset,
  zc_period_meter_if.slave bus
);

  localparam logic [1:0] S_SEEK  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic signed [DATA_W-1:0] HYST_P   = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] HYST_N   = -HYST_P;
  localparam logic        [CNT_W-1:0]  CNT_MAX  = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic        [CNT_W:0]    MIN_P    = (CNT_W+1)'(MIN_PERIOD);
  localparam logic        [IDX_W-1:0]  IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             first;
  logic [ACC_W-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] blk_sum;
  logic             blk_done;

  logic             flag_r;
  logic [CNT_W-1:0] period_r;
  logic             period_valid_r;
  logic [CNT_W-1:0] period_avg_r;
  logic             avg_valid_r;
  logic             locked_r;
  logic             overflow_r;

  logic             x_hi;
  logic             x_lo;
  logic [CNT_W:0]   cnt_ext;
  logic [CNT_W-1:0] cnt_nx;
  logic             accept;
  logic             measure;
  logic             timeout;
  logic [ACC_W-1:0] sum_nx;

  assign x_hi    = bus.x >= HYST_P;
  assign x_lo    = bus.x <  HYST_N;
  // cnt never exceeds CNT_MAX, so cnt+1 always fits in CNT_W bits
  assign cnt_ext = {1'b0, cnt} + (CNT_W+1)'(1);
  assign cnt_nx  = cnt_ext[CNT_W-1:0];
  assign accept  = bus.in_valid && (state == S_ARMED) && x_hi && (first || (cnt_ext >= MIN_P));
  assign measure = accept && !first;
  // a crossing on the same sample takes priority over the timeout
  assign timeout = bus.in_valid && !accept && (cnt == CNT_MAX);
  assign sum_nx  = acc + ACC_W'(cnt_nx);

  // Crossing FSM and sample counter, advanced only on valid samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_SEEK;
      cnt   <= '0;
      first <= 1'b1;
    end else if (bus.in_valid) begin
      if (timeout) begin
        state <= S_SEEK;
        cnt   <= '0;
        first <= 1'b1;
      end else begin
        case (state)
          S_SEEK:  if (x_lo) state <= S_ARMED;
          S_ARMED: if (x_hi) state <= S_HIGH;
          S_HIGH:  if (x_lo) state <= S_ARMED;
          default: state <= S_SEEK;
        endcase
        if (accept) begin
          cnt   <= '0;
          first <= 1'b0;
        end else if (state != S_SEEK) begin
          cnt <= cnt_nx;
        end
      end
    end
  end

  // Per-crossing outputs: flag pulse and instantaneous period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_r         <= 1'b0;
      period_valid_r <= 1'b0;
      period_r       <= '0;
    end else begin
      flag_r         <= accept;
      period_valid_r <= measure;
      if (measure) period_r <= cnt_nx;
    end
  end

  // Block accumulator; a completed block is handed to the output stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      idx      <= '0;
      blk_sum  <= '0;
      blk_done <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      if (timeout) begin
        acc <= '0;
        idx <= '0;
      end else if (measure) begin
        if (idx == IDX_LAST) begin
          blk_sum  <= sum_nx;
          blk_done <= 1'b1;
          acc      <= '0;
          idx      <= '0;
        end else begin
          acc <= sum_nx;
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  // Average, lock and sticky overflow outputs (one stage behind the period)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_avg_r <= '0;
      avg_valid_r  <= 1'b0;
      locked_r     <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      avg_valid_r <= blk_done;
      if (blk_done) begin
        period_avg_r <= CNT_W'(blk_sum >> AVG_LOG2);
        locked_r     <= 1'b1;
      end
      if (timeout) begin
        locked_r   <= 1'b0;
        overflow_r <= 1'b1;
      end
    end
  end

  assign bus.flag         = flag_r;
  assign bus.period       = period_r;
  assign bus.period_valid = period_valid_r;
  assign bus.period_avg   = period_avg_r;
  assign bus.avg_valid    = avg_valid_r;
  assign bus.locked       = locked_r;
  assign bus.overflow     = overflow_r;

endmodule
